// File: rtl/multiword_add_sequencer.sv
// ============================================================================
// Module      : multiword_add_sequencer
// Description : Wide add/subtract built from one WIDTH-bit adder slice, reused
//               once per word, least-significant word first, with a chained carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [TOTAL-1:0] r_a;
    logic [TOTAL-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [TOTAL-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_word;
    logic [WIDTH-1:0] w_b_word;
    logic [WIDTH:0]   w_slice;
    logic             w_last;
    logic             w_accept;

    // Operand B is stored pre-inverted for subtraction, so the slice only ever adds.
    always_comb begin
        w_a_word = r_a[r_idx*WIDTH +: WIDTH];
        w_b_word = r_b[r_idx*WIDTH +: WIDTH];
        w_slice  = {1'b0, w_a_word} + {1'b0, w_b_word} + {{WIDTH{1'b0}}, r_carry};
        w_last   = (r_idx == c_last_idx);
        w_accept = in_valid && (r_state == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*WIDTH +: WIDTH] <= w_slice[WIDTH-1:0];
                    r_carry                     <= w_slice[WIDTH];
                    if (w_last) begin
                        r_cout  <= w_slice[WIDTH];
                        // Signed overflow: like-signed operands giving a result of the other sign.
                        r_ovf   <= (w_a_word[WIDTH-1] == w_b_word[WIDTH-1]) &&
                                   (w_slice[WIDTH-1] != w_a_word[WIDTH-1]);
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
